// File: rtl/clk_enable_generator_pkg.sv
// Shared types and rate helpers for the fabric clock-enable generator.
// The run/stop state encoding, and conversion from a target frequency to an NCO increment.
package clk_gen_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam longint unsigned CLK_HZ        = 64'd36_000_000;
  localparam int              ACC_WIDTH_DEF = 32;

  // Rounded increment giving hz ticks per second at CLK_HZ with the default accumulator width.
  function automatic longint unsigned inc_for_hz(input longint unsigned hz);
    return ((hz << ACC_WIDTH_DEF) + (CLK_HZ >> 1)) / CLK_HZ;
  endfunction

endpackage

// File: rtl/clk_enable_generator_phase_accumulator.sv
// NCO core: acc += inc each enabled edge, with a registered carry strobe; a clear holds acc at zero.
// Latency: the carry appears on o_tick one cycle after the overflowing edge; there is no backpressure.
module phase_accumulator
  import clk_gen_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  input  logic                 i_clear,
  input  logic [ACC_WIDTH-1:0] i_inc,
  output logic                 o_carry,
  output logic                 o_tick,
  output logic                 o_msb
);

  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_tick;
  logic [ACC_WIDTH:0]   w_sum;

  assign w_sum   = {1'b0, r_acc} + {1'b0, i_inc};
  assign o_carry = i_enable & ~i_clear & w_sum[ACC_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= o_carry;
      if (i_clear) begin
        r_acc <= '0;
      end else if (i_enable) begin
        r_acc <= w_sum[ACC_WIDTH-1:0];
      end
    end
  end

  assign o_tick = r_tick;
  assign o_msb  = r_acc[ACC_WIDTH-1];

endmodule

// File: rtl/clk_enable_generator.sv
// Fractional clock-enable generator: NCO tick, every-DIV-th div_tick, and a rate update applied on tick boundaries.
// Latency: strobes are registered one cycle after the carry edge; inc_ready is low while an update is pending.
module clk_enable_generator
  import clk_gen_pkg::*;
#(
  parameter int                   ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = ACC_WIDTH'(119),
  parameter int                   DIV         = 60
) (
  input  logic                 clk_36MHz,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [ACC_WIDTH-1:0] inc_data,
  input  logic                 inc_valid,
  output logic                 inc_ready,
  output logic                 tick,
  output logic                 div_tick,
  output logic                 phase_msb,
  output logic                 running
);

  localparam int              DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_running;
  logic                 w_leave;
  logic                 w_accept;
  logic                 w_carry;
  logic                 w_div_last;
  logic                 r_pending;
  logic [ACC_WIDTH-1:0] r_inc;
  logic [ACC_WIDTH-1:0] r_pend_inc;
  logic [DIV_W-1:0]     r_div_cnt;
  logic                 r_div_tick;

  always_ff @(posedge clk_36MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= STOP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_running   = 1'b0;
    w_leave     = 1'b0;
    case (r_state)
      STOP: begin
        if (en) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_running = 1'b1;
        if (!en) begin
          w_state_nxt = STOP;
          w_leave     = 1'b1;
        end
      end
    endcase
  end

  // The first add happens on the STOP->RUN edge itself, so the accumulator simply follows en.
  phase_accumulator #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_phase_acc (
    .clk      (clk_36MHz),
    .rst_n    (reset_n),
    .i_enable (en),
    .i_clear  (~en),
    .i_inc    (r_inc),
    .o_carry  (w_carry),
    .o_tick   (tick),
    .o_msb    (phase_msb)
  );

  assign inc_ready = ~r_pending;
  assign w_accept  = inc_valid & ~r_pending;

  always_ff @(posedge clk_36MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_inc      <= DEFAULT_INC;
      r_pend_inc <= '0;
      r_pending  <= 1'b0;
    end else if (!w_running || w_leave) begin
      // Stopped or stopping: no period to protect, so apply immediately.
      if (w_accept) begin
        r_inc <= inc_data;
      end else if (r_pending) begin
        r_inc <= r_pend_inc;
      end
      r_pending <= 1'b0;
    end else if (r_pending) begin
      if (w_carry) begin
        r_inc     <= r_pend_inc;
        r_pending <= 1'b0;
      end
    end else if (w_accept) begin
      r_pend_inc <= inc_data;
      r_pending  <= 1'b1;
    end
  end

  assign w_div_last = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk_36MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt  <= '0;
      r_div_tick <= 1'b0;
    end else if (!en) begin
      r_div_cnt  <= '0;
      r_div_tick <= 1'b0;
    end else begin
      r_div_tick <= w_carry & w_div_last;
      if (w_carry) begin
        r_div_cnt <= w_div_last ? '0 : r_div_cnt + DIV_W'(1);
      end
    end
  end

  assign div_tick = r_div_tick;
  assign running  = (r_state == RUN);

endmodule
